// File: rtl/pe_mac_db.sv
// ---------------------------------------------------------------------------
// pe_mac_db
// Weight-stationary systolic multiply-accumulate processing element with a
// double-buffered weight register and optional partial-sum saturation.
//
// Several of these tile into a grid. Activations enter on ain and leave one
// cycle later on aout toward the element on the right. Partial sums enter
// from above on psum_in and leave downward on psum_out. Weights are shifted
// down a column through the shadow registers (win -> wout). A single global
// wswap then moves every shadow weight into its active register at once.
//
// Parameters
//   DATA_W  signed activation / weight width
//   ACC_W   signed partial-sum width, must be at least 2*DATA_W
//   SAT_EN  1 clamps psum_out to the ACC_W signed range, 0 wraps it
//
// Ports
//   clk         clock, every register updates on the rising edge
//   reset_n     synchronous active-low reset
//   wen         load win into the shadow weight
//   win         signed weight from the element above or the weight loader
//   wout        shadow weight, registered, toward the element below
//   wswap       copy the shadow weight into the active weight
//   w_pending   shadow holds a weight that has not been swapped in yet
//   ain         signed activation
//   ain_valid   ain and psum_in are meaningful this cycle
//   aout        ain delayed by one cycle
//   aout_valid  ain_valid delayed by one cycle
//   psum_in     signed partial sum from the element above
//   psum_out    registered psum_in + ain * active weight
//   psum_valid  psum_out was updated by the last edge
// ---------------------------------------------------------------------------
module pe_mac_db #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 32,
   parameter int SAT_EN = 1
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     wen,
   input  logic signed [DATA_W-1:0] win,
   output logic signed [DATA_W-1:0] wout,
   input  logic                     wswap,
   output logic                     w_pending,
   input  logic signed [DATA_W-1:0] ain,
   input  logic                     ain_valid,
   output logic signed [DATA_W-1:0] aout,
   output logic                     aout_valid,
   input  logic signed [ACC_W-1:0]  psum_in,
   output logic signed [ACC_W-1:0]  psum_out,
   output logic                     psum_valid
);

   localparam int PROD_W = 2 * DATA_W;

   // Limits of the ACC_W signed range, held one bit wider so they compare
   // directly against the unclamped sum.
   localparam logic signed [ACC_W:0] SUM_MAX = {2'b00, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W:0] SUM_MIN = {2'b11, {(ACC_W-1){1'b0}}};

   logic signed [DATA_W-1:0] shadow_w;
   logic signed [DATA_W-1:0] active_w;
   logic signed [PROD_W-1:0] ain_ext;
   logic signed [PROD_W-1:0] w_ext;
   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W:0]    sum_ext;
   logic signed [ACC_W-1:0]  mac_result;

   // The shadow register doubles as the weight-chain output. The next element
   // down therefore sees a weight exactly one wen later, and the column behaves
   // as a plain shift register.
   assign wout = shadow_w;

   // Weight double buffer. The swap always reads the shadow value from before
   // the edge. A wen and a wswap in the same cycle therefore promote the old
   // shadow weight and capture the new one. In that case the pending flag stays
   // set, because the shadow again holds something not yet promoted.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         shadow_w  <= '0;
         active_w  <= '0;
         w_pending <= 1'b0;
      end else begin
         if (wswap) begin
            active_w <= shadow_w;
         end
         if (wen) begin
            shadow_w  <= win;
            w_pending <= 1'b1;
         end else if (wswap) begin
            w_pending <= 1'b0;
         end
      end
   end

   // Activation forwarding to the element on the right. It runs every cycle,
   // whatever the weight path is doing, so a row of elements skews its inputs
   // by one cycle per column.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         aout       <= '0;
         aout_valid <= 1'b0;
      end else begin
         aout       <= ain;
         aout_valid <= ain_valid;
      end
   end

   // Multiply-accumulate datapath. Both operands are sign-extended to the full
   // product width before the multiply. This keeps the most-negative squared
   // case exact, for example -128 * -128 = +16384. The sum is formed one bit
   // wider than the accumulator so any overflow is visible before it is
   // clamped or wrapped.
   always_comb begin
      ain_ext    = {{DATA_W{ain[DATA_W-1]}}, ain};
      w_ext      = {{DATA_W{active_w[DATA_W-1]}}, active_w};
      prod       = ain_ext * w_ext;
      sum_ext    = {psum_in[ACC_W-1], psum_in}
                 + {{(ACC_W+1-PROD_W){prod[PROD_W-1]}}, prod};
      mac_result = sum_ext[ACC_W-1:0];
      if (SAT_EN != 0) begin
         if (sum_ext > SUM_MAX) begin
            mac_result = SUM_MAX[ACC_W-1:0];
         end else if (sum_ext < SUM_MIN) begin
            mac_result = SUM_MIN[ACC_W-1:0];
         end
      end
   end

   // Partial-sum output register. It only captures on a valid activation.
   // Otherwise the last result is held and the valid flag drops, so the
   // element below sees exactly one valid per accepted input.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         psum_out   <= '0;
         psum_valid <= 1'b0;
      end else begin
         psum_valid <= ain_valid;
         if (ain_valid) begin
            psum_out <= mac_result;
         end
      end
   end

endmodule

// File: tb/tb_pe_mac_db.sv
// ---------------------------------------------------------------------------
// tb_pe_mac_db
// Self-checking bench for pe_mac_db. Three single elements share one input
// stream: the default 32-bit saturating element, a 16-bit saturating one and
// a 16-bit wrapping one. A behavioural model predicts their outputs every
// cycle from plain integer arithmetic. A separate four-element column
// exercises weight shifting and the vertical partial-sum chain.
// ---------------------------------------------------------------------------
module tb_pe_mac_db;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               reset_n;
   logic               wen;
   logic               wswap;
   logic               ain_valid;
   logic signed [7:0]  win;
   logic signed [7:0]  ain;
   logic signed [31:0] psum_in;

   logic signed [7:0]  wout32, aout32, wout16s, aout16s, wout16w, aout16w;
   logic               wp32, av32, pv32, wp16s, av16s, pv16s, wp16w, av16w, pv16w;
   logic signed [31:0] psum32;
   logic signed [15:0] psum16s, psum16w;

   int nChecks = 0;
   int nErrors = 0;

   pe_mac_db #(.DATA_W(8), .ACC_W(32), .SAT_EN(1)) dut32 (
      .clk(clk), .reset_n(reset_n), .wen(wen), .win(win), .wout(wout32),
      .wswap(wswap), .w_pending(wp32), .ain(ain), .ain_valid(ain_valid),
      .aout(aout32), .aout_valid(av32), .psum_in(psum_in),
      .psum_out(psum32), .psum_valid(pv32));

   pe_mac_db #(.DATA_W(8), .ACC_W(16), .SAT_EN(1)) dut16s (
      .clk(clk), .reset_n(reset_n), .wen(wen), .win(win), .wout(wout16s),
      .wswap(wswap), .w_pending(wp16s), .ain(ain), .ain_valid(ain_valid),
      .aout(aout16s), .aout_valid(av16s), .psum_in(psum_in[15:0]),
      .psum_out(psum16s), .psum_valid(pv16s));

   pe_mac_db #(.DATA_W(8), .ACC_W(16), .SAT_EN(0)) dut16w (
      .clk(clk), .reset_n(reset_n), .wen(wen), .win(win), .wout(wout16w),
      .wswap(wswap), .w_pending(wp16w), .ain(ain), .ain_valid(ain_valid),
      .aout(aout16w), .aout_valid(av16w), .psum_in(psum_in[15:0]),
      .psum_out(psum16w), .psum_valid(pv16w));

   // Four-element column: weights shift down through wout -> win, and partial
   // sums flow down through psum_out -> psum_in.
   logic               cWen, cWswap, cValid;
   logic signed [7:0]  cAin;
   logic signed [7:0]  cW [0:4];
   logic signed [31:0] cPsum [0:4];
   logic               cPend [0:3];
   logic signed [7:0]  cAout [0:3];
   logic               cAv [0:3];
   logic               cPv [0:3];

   assign cPsum[0] = 32'sd0;

   for (genvar g = 0; g < 4; g++) begin : g_col
      pe_mac_db #(.DATA_W(8), .ACC_W(32), .SAT_EN(1)) pe (
         .clk(clk), .reset_n(reset_n), .wen(cWen), .win(cW[g]), .wout(cW[g+1]),
         .wswap(cWswap), .w_pending(cPend[g]), .ain(cAin), .ain_valid(cValid),
         .aout(cAout[g]), .aout_valid(cAv[g]), .psum_in(cPsum[g]),
         .psum_out(cPsum[g+1]), .psum_valid(cPv[g]));
   end

   // Behavioural model state.
   bit     started = 1'b0;
   longint mShadow, mActive, mAout, mP32, mP16s, mP16w;
   bit     mPending, mAv, mPv;

   // Fit an unbounded sum into a w-bit signed accumulator, either clamping it
   // to the representable range or keeping only its low w bits.
   function automatic longint fitAcc(longint v, int w, bit sat);
      longint mx = (longint'(1) << (w - 1)) - 1;
      longint mn = -mx - 1;
      int     sh = 64 - w;
      if (sat) begin
         if (v > mx) return mx;
         if (v < mn) return mn;
         return v;
      end
      return (v <<< sh) >>> sh;
   endfunction

   // Reference model, updated once per rising edge from the sampled inputs.
   always @(posedge clk) begin
      longint p;
      if (!reset_n) begin
         mShadow = 0; mActive = 0; mPending = 0;
         mAout = 0; mAv = 0; mP32 = 0; mP16s = 0; mP16w = 0; mPv = 0;
         started = 1'b1;
      end else begin
         if (ain_valid) begin
            p     = longint'(ain) * mActive;
            mP32  = fitAcc(longint'(psum_in) + p, 32, 1'b1);
            mP16s = fitAcc(longint'($signed(psum_in[15:0])) + p, 16, 1'b1);
            mP16w = fitAcc(longint'($signed(psum_in[15:0])) + p, 16, 1'b0);
         end
         mPv   = ain_valid;
         mAout = longint'(ain);
         mAv   = ain_valid;
         if (wswap) mActive = mShadow;
         if (wen) begin
            mShadow  = longint'(win);
            mPending = 1'b1;
         end else if (wswap) begin
            mPending = 1'b0;
         end
      end
   end

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      nChecks++;
      if (actual !== expected) begin
         nErrors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the model, on the falling edge.
   always @(negedge clk) begin
      if (started) begin
         checkOutput("psum32",   longint'(psum32),  mP32);
         checkOutput("psum16s",  longint'(psum16s), mP16s);
         checkOutput("psum16w",  longint'(psum16w), mP16w);
         checkOutput("pvalid32", longint'(pv32),    longint'(mPv));
         checkOutput("pvalid16", longint'(pv16w),   longint'(mPv));
         checkOutput("aout",     longint'(aout32),  mAout);
         checkOutput("avalid",   longint'(av32),    longint'(mAv));
         checkOutput("wout",     longint'(wout32),  mShadow);
         checkOutput("wpending", longint'(wp32),    longint'(mPending));
      end
   end

   // Drive one cycle of inputs to the single elements, then step to just
   // after the next rising edge.
   task automatic applyStimulus(input logic rn, input logic we, input logic signed [7:0] wi,
                                input logic ws, input logic signed [7:0] a, input logic v,
                                input logic signed [31:0] p);
      reset_n = rn; wen = we; win = wi; wswap = ws; ain = a; ain_valid = v; psum_in = p;
      @(posedge clk);
      #1;
   endtask

   task automatic chainStep(input logic we, input logic signed [7:0] wi, input logic ws,
                            input logic signed [7:0] a, input logic v);
      cWen = we; cW[0] = wi; cWswap = ws; cAin = a; cValid = v;
      @(posedge clk);
      #1;
   endtask

   function automatic logic signed [7:0] randData();
      case ($urandom_range(0, 5))
         0:       return -8'sd128;
         1:       return 8'sd127;
         default: return 8'($urandom);
      endcase
   endfunction

   function automatic logic signed [31:0] randPsum();
      case ($urandom_range(0, 5))
         0:       return 32'sh7FFF_FF00 + 32'($urandom_range(0, 255));
         1:       return 32'sh8000_0000 + 32'($urandom_range(0, 255));
         2:       return 32'($signed(16'sh7F00 + 16'($urandom_range(0, 255))));
         3:       return 32'($signed(16'sh8000 + 16'($urandom_range(0, 255))));
         default: return 32'($urandom);
      endcase
   endfunction

   initial begin
      cWen = 0; cWswap = 0; cValid = 0; cAin = 0; cW[0] = 0;

      // Reset with random traffic on every input.
      for (int i = 0; i < 2; i++)
         applyStimulus(1'b0, 1'b1, randData(), 1'b1, randData(), 1'b1, randPsum());
      checkOutput("rst_psum",   longint'(psum32),  0);
      checkOutput("rst_psum16", longint'(psum16s), 0);
      checkOutput("rst_pvalid", longint'(pv32),    0);
      checkOutput("rst_aout",   longint'(aout32),  0);
      checkOutput("rst_avalid", longint'(av32),    0);
      checkOutput("rst_wout",   longint'(wout32),  0);
      checkOutput("rst_wpend",  longint'(wp32),    0);

      // Basic MAC: weight 3, -5 * 3 + 100 = 85, then hold.
      applyStimulus(1, 1, 8'sd3, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, -8'sd5, 1, 100);
      checkOutput("basic_psum",   longint'(psum32), 85);
      checkOutput("basic_pvalid", longint'(pv32),   1);
      checkOutput("basic_aout",   longint'(aout32), -5);
      checkOutput("basic_avalid", longint'(av32),   1);
      checkOutput("basic_model",  mP32,             85);
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      checkOutput("hold_psum",    longint'(psum32), 85);
      checkOutput("hold_pvalid",  longint'(pv32),   0);

      // Swap in the same cycle as a valid uses the old active weight.
      applyStimulus(1, 1, 8'sd2, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 1, 0, 0, 0);
      applyStimulus(1, 1, 8'sd7, 0, 0, 0, 0);
      checkOutput("swap_pend", longint'(wp32),   1);
      checkOutput("swap_wout", longint'(wout32), 7);
      applyStimulus(1, 0, 0, 1, 8'sd10, 1, 0);
      checkOutput("swap_old",  longint'(psum32), 20);
      checkOutput("swap_clr",  longint'(wp32),   0);
      applyStimulus(1, 0, 0, 0, 8'sd10, 1, 0);
      checkOutput("swap_new",  longint'(psum32), 70);
      applyStimulus(1, 1, 8'sd9, 1, 0, 0, 0);
      checkOutput("wenswap_wout", longint'(wout32), 9);
      checkOutput("wenswap_pend", longint'(wp32),   1);
      applyStimulus(1, 0, 0, 0, 8'sd1, 1, 0);
      checkOutput("wenswap_act",  longint'(psum32), 7);

      // Saturation and wrap on 16-bit accumulators, plus the exact -128*-128.
      applyStimulus(1, 1, -8'sd128, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, -8'sd128, 1, 0);
      checkOutput("edge_prod",  longint'(psum32),  16384);
      applyStimulus(1, 0, 0, 0, -8'sd128, 1, 32767);
      checkOutput("sat_hi",     longint'(psum16s), 32767);
      checkOutput("wrap_hi",    longint'(psum16w), -16385);
      checkOutput("nosat32",    longint'(psum32),  49151);
      applyStimulus(1, 1, 8'sd127, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, -8'sd128, 1, -32768);
      checkOutput("sat_lo",     longint'(psum16s), -32768);
      checkOutput("wrap_lo",    longint'(psum16w), 16512);
      checkOutput("sat_lo_mdl", mP16s,             -32768);

      // Reset in the middle of back-to-back valids.
      applyStimulus(1, 0, 0, 0, 8'sd4, 1, 11);
      applyStimulus(1, 0, 0, 0, 8'sd5, 1, 22);
      applyStimulus(0, 0, 0, 0, 8'sd6, 1, 33);
      checkOutput("mid_pvalid", longint'(pv32),   0);
      checkOutput("mid_psum",   longint'(psum32), 0);
      applyStimulus(1, 0, 0, 0, 8'sd5, 1, 123);
      checkOutput("mid_zero_w", longint'(psum32), 123);

      // Randomised traffic with occasional resets.
      for (int i = 0; i < 3000; i++)
         applyStimulus(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) == 0), randData(),
                       ($urandom_range(0, 4) == 0), randData(), ($urandom_range(0, 2) != 0),
                       randPsum());

      // Column: shift 4,3,2,1 so the top holds 1 and the bottom holds 4.
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      chainStep(1, 8'sd4, 0, 0, 0);
      chainStep(1, 8'sd3, 0, 0, 0);
      chainStep(1, 8'sd2, 0, 0, 0);
      chainStep(1, 8'sd1, 0, 0, 0);
      checkOutput("col_pend_set", longint'(cPend[3]), 1);
      chainStep(0, 0, 1, 0, 0);
      for (int i = 0; i < 4; i++)
         checkOutput("col_pend_clr", longint'(cPend[i]), 0);
      for (int i = 0; i < 4; i++)
         chainStep(0, 0, 0, 8'sd1, 1);
      checkOutput("col_sum",    longint'(cPsum[4]), 10);
      checkOutput("col_pvalid", longint'(cPv[3]),   1);
      checkOutput("col_mid",    longint'(cPsum[2]), 3);
      checkOutput("col_aout",   longint'(cAout[3]) + longint'(cAv[0]), 2);
      chainStep(0, 0, 0, 0, 0);

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
